// File: rtl/int_exec_unit.sv
// Single-lane integer execution unit: stall-able operand/control register feeding
// combinational ALU, shifter, select, link-address and branch-condition logic.
module int_exec_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [1:0]            in_op_type,
  input  logic [3:0]            in_alu_code,
  input  logic                  in_shift_src,
  input  logic [1:0]            in_shift_type,
  input  logic [4:0]            in_shift_imm,
  input  logic [2:0]            in_cond,
  input  logic [DATA_WIDTH-1:0] in_op_a,
  input  logic [DATA_WIDTH-1:0] in_op_b,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_cond,
  output logic                  out_shift_carry
);

  localparam logic [1:0] OpAlu    = 2'd0;
  localparam logic [1:0] OpShift  = 2'd1;
  localparam logic [1:0] OpBr     = 2'd2;
  localparam logic [1:0] OpSelect = 2'd3;

  localparam logic [1:0] ShSll = 2'd0;
  localparam logic [1:0] ShSrl = 2'd1;
  localparam logic [1:0] ShSra = 2'd2;
  localparam logic [1:0] ShRor = 2'd3;

  logic                  valid_q, valid_d;
  logic [1:0]            op_type_q, op_type_d;
  logic [3:0]            alu_code_q, alu_code_d;
  logic                  shift_src_q, shift_src_d;
  logic [1:0]            shift_type_q, shift_type_d;
  logic [4:0]            shift_imm_q, shift_imm_d;
  logic [2:0]            cond_q, cond_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;

  // Reset takes priority over stall so a frozen op cannot survive a reset.
  always_comb begin
    valid_d      = valid_q;
    op_type_d    = op_type_q;
    alu_code_d   = alu_code_q;
    shift_src_d  = shift_src_q;
    shift_type_d = shift_type_q;
    shift_imm_d  = shift_imm_q;
    cond_d       = cond_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    pc_d         = pc_q;
    if (rst) begin
      valid_d      = 1'b0;
      op_type_d    = '0;
      alu_code_d   = '0;
      shift_src_d  = 1'b0;
      shift_type_d = '0;
      shift_imm_d  = '0;
      cond_d       = '0;
      op_a_d       = '0;
      op_b_d       = '0;
      pc_d         = '0;
    end else if (!stall) begin
      valid_d      = in_valid;
      op_type_d    = in_op_type;
      alu_code_d   = in_alu_code;
      shift_src_d  = in_shift_src;
      shift_type_d = in_shift_type;
      shift_imm_d  = in_shift_imm;
      cond_d       = in_cond;
      op_a_d       = in_op_a;
      op_b_d       = in_op_b;
      pc_d         = in_pc;
    end
  end

  always_ff @(posedge clk) begin
    valid_q      <= valid_d;
    op_type_q    <= op_type_d;
    alu_code_q   <= alu_code_d;
    shift_src_q  <= shift_src_d;
    shift_type_q <= shift_type_d;
    shift_imm_q  <= shift_imm_d;
    cond_q       <= cond_d;
    op_a_q       <= op_a_d;
    op_b_q       <= op_b_d;
    pc_q         <= pc_d;
  end

  logic lt_s, lt_u, cond_res;

  always_comb begin
    lt_s = $signed(op_a_q) < $signed(op_b_q);
    lt_u = op_a_q < op_b_q;
    unique case (cond_q)
      3'd0:    cond_res = (op_a_q == op_b_q);
      3'd1:    cond_res = (op_a_q != op_b_q);
      3'd2:    cond_res = lt_s;
      3'd3:    cond_res = lt_u;
      3'd4:    cond_res = !lt_s;
      3'd5:    cond_res = !lt_u;
      3'd6:    cond_res = 1'b1;
      default: cond_res = 1'b0;
    endcase
  end

  logic [DATA_WIDTH-1:0] alu_res;

  always_comb begin
    case (alu_code_q)
      4'd0:    alu_res = op_a_q + op_b_q;
      4'd1:    alu_res = op_a_q - op_b_q;
      4'd2:    alu_res = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      4'd3:    alu_res = {{(DATA_WIDTH-1){1'b0}}, lt_u};
      4'd4:    alu_res = op_a_q ^ op_b_q;
      4'd5:    alu_res = op_a_q | op_b_q;
      4'd6:    alu_res = op_a_q & op_b_q;
      4'd7:    alu_res = op_b_q;
      default: alu_res = '0;
    endcase
  end

  logic [4:0]              sh_amt;
  logic [DATA_WIDTH:0]     sll_ext, srl_ext, sra_ext;
  logic [2*DATA_WIDTH-1:0] ror_ext;
  logic [DATA_WIDTH-1:0]   sh_res;
  logic                    sh_carry;

  // One guard bit beside A catches the last bit shifted out; it is 0 when n=0.
  always_comb begin
    sh_amt  = shift_src_q ? op_b_q[4:0] : shift_imm_q;
    sll_ext = {1'b0, op_a_q} << sh_amt;
    srl_ext = {op_a_q, 1'b0} >> sh_amt;
    sra_ext = $unsigned($signed({op_a_q, 1'b0}) >>> sh_amt);
    ror_ext = {op_a_q, op_a_q} >> sh_amt;
    unique case (shift_type_q)
      ShSll: begin
        sh_res   = sll_ext[DATA_WIDTH-1:0];
        sh_carry = sll_ext[DATA_WIDTH];
      end
      ShSrl: begin
        sh_res   = srl_ext[DATA_WIDTH:1];
        sh_carry = srl_ext[0];
      end
      ShSra: begin
        sh_res   = sra_ext[DATA_WIDTH:1];
        sh_carry = sra_ext[0];
      end
      default: begin
        sh_res   = ror_ext[DATA_WIDTH-1:0];
        sh_carry = (sh_amt != 5'd0) & ror_ext[DATA_WIDTH-1];
      end
    endcase
  end

  always_comb begin
    unique case (op_type_q)
      OpAlu:    out_data = alu_res;
      OpShift:  out_data = sh_res;
      OpBr:     out_data = pc_q + DATA_WIDTH'(4);
      OpSelect: out_data = cond_res ? op_a_q : op_b_q;
      default:  out_data = alu_res;
    endcase
    out_valid       = valid_q & !stall & !clear & !rst;
    out_cond        = cond_res;
    out_shift_carry = sh_carry;
  end

endmodule

// File: tb/tb_int_exec_unit.sv
// Bench for int_exec_unit: directed literal checks plus randomized traffic compared every
// cycle against a behavioural model of the latched op.
module tb_int_exec_unit;

  logic        clk = 1'b0;
  logic        rst, stall, clear, in_valid;
  logic [1:0]  in_op_type, in_shift_type;
  logic [3:0]  in_alu_code;
  logic        in_shift_src;
  logic [4:0]  in_shift_imm;
  logic [2:0]  in_cond;
  logic [31:0] in_op_a, in_op_b, in_pc;
  logic        out_valid, out_cond, out_shift_carry;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  int_exec_unit #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .clear          (clear),
    .in_valid       (in_valid),
    .in_op_type     (in_op_type),
    .in_alu_code    (in_alu_code),
    .in_shift_src   (in_shift_src),
    .in_shift_type  (in_shift_type),
    .in_shift_imm   (in_shift_imm),
    .in_cond        (in_cond),
    .in_op_a        (in_op_a),
    .in_op_b        (in_op_b),
    .in_pc          (in_pc),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_cond       (out_cond),
    .out_shift_carry(out_shift_carry)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [1:0]  ot;
    logic [3:0]  ac;
    logic        ss;
    logic [1:0]  st;
    logic [4:0]  imm;
    logic [2:0]  cc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
  } op_t;

  op_t model_op;
  bit  model_init = 1'b0;

  function automatic bit m_cond(op_t o);
    int sa = int'(o.a);
    int sb = int'(o.b);
    case (o.cc)
      3'd0: return o.a == o.b;
      3'd1: return o.a != o.b;
      3'd2: return sa < sb;
      3'd3: return o.a < o.b;
      3'd4: return sa >= sb;
      3'd5: return o.a >= o.b;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Shift one bit at a time, remembering the bit that falls off.
  function automatic logic [32:0] m_shift(op_t o);
    int unsigned n = o.ss ? int'(o.b[4:0]) : int'(o.imm);
    logic [31:0] r = o.a;
    logic c = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      case (o.st)
        2'd0: begin c = r[31]; r = {r[30:0], 1'b0}; end
        2'd1: begin c = r[0];  r = {1'b0, r[31:1]}; end
        2'd2: begin c = r[0];  r = {r[31], r[31:1]}; end
        default: begin r = {r[0], r[31:1]}; c = r[31]; end
      endcase
    end
    return {c, r};
  endfunction

  function automatic logic [31:0] m_data(op_t o);
    logic [32:0] sh = m_shift(o);
    case (o.ot)
      2'd0: case (o.ac)
        4'd0: return o.a + o.b;
        4'd1: return o.a - o.b;
        4'd2: return (int'(o.a) < int'(o.b)) ? 32'd1 : 32'd0;
        4'd3: return (o.a < o.b) ? 32'd1 : 32'd0;
        4'd4: return o.a ^ o.b;
        4'd5: return o.a | o.b;
        4'd6: return o.a & o.b;
        4'd7: return o.b;
        default: return 32'd0;
      endcase
      2'd1: return sh[31:0];
      2'd2: return o.pc + 32'd4;
      default: return m_cond(o) ? o.a : o.b;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model of the pipeline register.
  always @(posedge clk) begin
    if (rst) begin
      model_op   = '0;
      model_init = 1'b1;
    end else if (!stall) begin
      model_op = {in_valid, in_op_type, in_alu_code, in_shift_src, in_shift_type,
                  in_shift_imm, in_cond, in_op_a, in_op_b, in_pc};
    end
  end

  always @(negedge clk) begin
    if (model_init) begin
      logic [32:0] sh;
      sh = m_shift(model_op);
      chk("cyc_valid", 32'(out_valid), 32'(model_op.v & !stall & !clear & !rst));
      chk("cyc_data", out_data, m_data(model_op));
      chk("cyc_cond", 32'(out_cond), 32'(m_cond(model_op)));
      chk("cyc_carry", 32'(out_shift_carry), 32'(sh[32]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(logic [1:0] ot, logic [3:0] ac, logic ss, logic [1:0] st,
                        logic [4:0] imm, logic [2:0] cc, logic [31:0] a, logic [31:0] b,
                        logic [31:0] pc);
    in_valid      = 1'b1;
    in_op_type    = ot;
    in_alu_code   = ac;
    in_shift_src  = ss;
    in_shift_type = st;
    in_shift_imm  = imm;
    in_cond       = cc;
    in_op_a       = a;
    in_op_b       = b;
    in_pc         = pc;
  endtask

  task automatic dir_op(string nm, logic [1:0] ot, logic [3:0] ac, logic ss, logic [1:0] st,
                        logic [4:0] imm, logic [2:0] cc, logic [31:0] a, logic [31:0] b,
                        logic [31:0] pc, logic [31:0] exp_data, logic exp_cond,
                        logic exp_carry);
    set_op(ot, ac, ss, st, imm, cc, a, b, pc);
    tick();
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_data"}, out_data, exp_data);
    chk({nm, "_cond"}, 32'(out_cond), 32'(exp_cond));
    chk({nm, "_carry"}, 32'(out_shift_carry), 32'(exp_carry));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; clear = 1'b0;
    set_op(2'd0, 4'd0, 1'b0, 2'd0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    in_valid = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_cond", 32'(out_cond), 32'd1);
    chk("rst_carry", 32'(out_shift_carry), 32'd0);
    rst = 1'b0;

    // ALU on A=-1, B=1 (cond EQ -> 0)
    dir_op("add", 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 32'h0, 0, 0);
    dir_op("sub", 0, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFE, 0, 0);
    dir_op("slt", 0, 2, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 32'h1, 0, 0);
    dir_op("sltu", 0, 3, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 32'h0, 0, 0);
    dir_op("and", 0, 6, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 32'h1, 0, 0);
    dir_op("alu12", 0, 12, 0, 0, 0, 6, 32'hFFFFFFFF, 1, 0, 32'h0, 1, 0);
    // Shifter on A=0x80000001
    dir_op("sra4", 1, 0, 0, 2, 4, 1, 32'h80000001, 0, 0, 32'hF8000000, 1, 0);
    dir_op("srl_b", 1, 0, 1, 1, 9, 1, 32'h80000001, 32'h21, 0, 32'h40000000, 1, 1);
    dir_op("ror1", 1, 0, 0, 3, 1, 1, 32'h80000001, 0, 0, 32'hC0000000, 1, 1);
    dir_op("sll0", 1, 0, 0, 0, 0, 1, 32'h80000001, 0, 0, 32'h80000001, 1, 0);
    // Conditions via SELECT, A=-1, B=1
    dir_op("sel_lt", 3, 0, 0, 0, 0, 2, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0);
    dir_op("sel_geu", 3, 0, 0, 0, 0, 5, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0);
    dir_op("sel_eq", 3, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 32'h1, 0, 0);
    dir_op("sel_ap", 3, 0, 0, 0, 0, 7, 32'hFFFFFFFF, 1, 0, 32'h1, 0, 0);
    // Link address
    dir_op("br_wrap", 2, 0, 0, 0, 0, 6, 0, 0, 32'hFFFFFFFC, 32'h0, 1, 0);
    dir_op("br_1000", 2, 0, 0, 0, 0, 6, 0, 0, 32'h1000, 32'h1004, 1, 0);

    // Stall holds X (3+4) while a different op waits at the inputs
    dir_op("x_load", 0, 0, 0, 0, 0, 0, 3, 4, 0, 32'd7, 0, 0);
    stall = 1'b1;
    set_op(0, 0, 0, 0, 0, 0, 10, 20, 0);
    #1;
    chk("stall0_valid", 32'(out_valid), 32'd0);
    for (int i = 1; i <= 2; i++) begin
      tick();
      chk("stall_valid", 32'(out_valid), 32'd0);
      chk("stall_data", out_data, 32'd7);
    end
    stall = 1'b0;
    #1;
    chk("unstall_valid", 32'(out_valid), 32'd1);
    chk("unstall_data", out_data, 32'd7);
    tick();
    chk("next_valid", 32'(out_valid), 32'd1);
    chk("next_data", out_data, 32'd30);
    clear = 1'b1;
    #1;
    chk("clear_valid", 32'(out_valid), 32'd0);
    tick();
    clear = 1'b0;
    #1;
    chk("post_clear_valid", 32'(out_valid), 32'd1);
    chk("post_clear_data", out_data, 32'd30);

    // Reset with a valid op in flight; stall also high to confirm reset wins
    set_op(1, 0, 0, 0, 3, 1, 32'h80000001, 5, 0);
    tick();
    rst = 1'b1;
    stall = 1'b1;
    tick();
    rst = 1'b0;
    stall = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", out_data, 32'd0);
    chk("midrst_carry", 32'(out_shift_carry), 32'd0);
    tick();
    chk("idle_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    tick();
    chk("new_valid", 32'(out_valid), 32'd1);

    // Randomized traffic, checked by the per-cycle compare process
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 63);
      set_op(2'($urandom), 4'($urandom), 1'($urandom), 2'($urandom), 5'($urandom),
             3'($urandom), a, b, $urandom);
      in_valid = ($urandom_range(0, 9) < 8);
      stall    = ($urandom_range(0, 9) < 2);
      clear    = ($urandom_range(0, 9) == 0);
      rst      = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0; stall = 1'b0; clear = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
